// File: rtl/anode_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display: shadow word loaded via req/ack
// only at frame boundaries, one active-low anode rotated per prescaled digit slot.
module anode_scan_ctrl #(
  parameter int ANCHO = 4,
  parameter int PRESC = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_req,
  input  logic [(2**ANCHO)-1:0]         wr_data,
  input  logic                          blank,
  output logic                          wr_ack,
  output logic                          busy,
  output logic [((2**ANCHO)/4)-1:0]     an,
  output logic [3:0]                    digit
);

  localparam int DW    = 2**ANCHO;
  localparam int N_DIG = DW / 4;
  localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int IW    = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_SCAN = 2'd2
  } state_t;

  state_t         state_q;
  logic [DW-1:0]  shadow_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_d;
  logic [PW-1:0]  presc_q;
  logic [PW-1:0]  presc_d;
  logic           tick;

  assign tick    = (presc_q == PRESC_LAST);
  assign presc_d = tick ? '0 : presc_q + 1'b1;
  // Explicit wrap keeps idx inside the shadow even for non-power-of-2 digit counts.
  assign idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      presc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          if (wr_req) state_q <= S_LOAD;
        end
        S_LOAD: begin
          shadow_q <= wr_data;
          idx_q    <= '0;
          presc_q  <= '0;
          state_q  <= S_SCAN;
        end
        S_SCAN: begin
          presc_q <= presc_d;
          // Requests are only honoured at the frame-end tick; idx stays on the
          // last digit through LOAD so the frame is never mixed.
          if (tick) begin
            if ((idx_q == IDX_LAST) && wr_req) state_q <= S_LOAD;
            else                               idx_q   <= idx_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    an    = '1;
    digit = '0;
    for (int k = 0; k < N_DIG; k++) begin
      if ((state_q != S_IDLE) && (idx_q == IW'(k))) begin
        an[k] = blank;
        digit = shadow_q[4*k +: 4];
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign wr_ack = (state_q == S_LOAD);

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Scoreboard bench for anode_scan_ctrl (ANCHO=4, PRESC=4): expected per-cycle
// {wr_ack, busy, an, digit} vectors are queued per scenario and popped each cycle.
module tb_anode_scan_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        blank;
  logic        wr_ack;
  logic        busy;
  logic [3:0]  an;
  logic [3:0]  digit;

  int n_cmp = 0;
  int n_err = 0;
  logic [9:0] sb[$];

  anode_scan_ctrl #(.ANCHO(4), .PRESC(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_req  (wr_req),
    .wr_data (wr_data),
    .blank   (blank),
    .wr_ack  (wr_ack),
    .busy    (busy),
    .an      (an),
    .digit   (digit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] ev(input logic a, input logic b,
                                    input logic [3:0] an_v, input logic [3:0] d);
    return {a, b, an_v, d};
  endfunction

  function automatic logic [3:0] an_of(input int idx);
    logic [3:0] v;
    v = 4'hF;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic push_slot(input int idx, input logic [15:0] w, input int n, input logic blk);
    for (int j = 0; j < n; j++)
      sb.push_back(ev(1'b0, 1'b1, blk ? 4'hF : an_of(idx), w[4*idx +: 4]));
  endtask

  task automatic push_frame(input logic [15:0] w);
    for (int d = 0; d < 4; d++) push_slot(d, w, 4, 1'b0);
  endtask

  task automatic test_reset;
    logic [9:0] e, o;
    rst = 1'b0; wr_req = 1'b1; wr_data = 16'hA3C5; blank = 1'b0;
    for (int j = 0; j < 3; j++) sb.push_back(ev(1'b0, 1'b0, 4'hF, 4'h0));
    sb.push_back(ev(1'b1, 1'b1, 4'b1110, 4'h0));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset cyc%0d: got %b want %b", i, o, e);
      end
      if (i == 2) rst = 1'b1;
      if (i == 3) wr_req = 1'b0;
    end
  endtask

  task automatic test_first_load;
    logic [9:0] e, o;
    int n;
    push_frame(16'hA3C5);
    push_slot(0, 16'hA3C5, 4, 1'b0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL first_load cyc%0d: got %b want %b", i, o, e);
      end
    end
  endtask

  task automatic test_mid_frame;
    logic [9:0] e, o;
    int n;
    push_slot(1, 16'hA3C5, 4, 1'b0);
    push_slot(2, 16'hA3C5, 4, 1'b0);
    push_slot(3, 16'hA3C5, 4, 1'b0);
    sb.push_back(ev(1'b1, 1'b1, 4'b0111, 4'hA));
    push_frame(16'h1234);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL mid_frame cyc%0d: got %b want %b", i, o, e);
      end
      if (i == 0) begin wr_req = 1'b1; wr_data = 16'h1234; end
      if (i == 12) wr_req = 1'b0;
    end
  endtask

  task automatic test_blank;
    logic [9:0] e, o;
    int n;
    push_slot(0, 16'h1234, 1, 1'b0);
    push_slot(0, 16'h1234, 3, 1'b1);
    push_slot(1, 16'h1234, 3, 1'b1);
    push_slot(1, 16'h1234, 1, 1'b0);
    push_slot(2, 16'h1234, 4, 1'b0);
    push_slot(3, 16'h1234, 4, 1'b0);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL blank cyc%0d: got %b want %b", i, o, e);
      end
      if (i == 0) blank = 1'b1;
      if (i == 6) blank = 1'b0;
    end
  endtask

  task automatic test_reset_mid_load;
    logic [9:0] e, o;
    int n;
    wr_req = 1'b1; wr_data = 16'hBEEF;
    sb.push_back(ev(1'b1, 1'b1, 4'b0111, 4'h1));
    for (int j = 0; j < 4; j++) sb.push_back(ev(1'b0, 1'b0, 4'hF, 4'h0));
    sb.push_back(ev(1'b1, 1'b1, 4'b1110, 4'h0));
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL reset_mid_load cyc%0d: got %b want %b", i, o, e);
      end
      if (i == 0) rst = 1'b0;
      if (i == 2) begin rst = 1'b1; wr_req = 1'b0; end
      if (i == 4) begin wr_req = 1'b1; wr_data = 16'hBEEF; end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] e, o;
    logic [15:0] w [3];
    int n, last_ack;
    w[0] = 16'hBEEF; w[1] = 16'h0F1E; w[2] = 16'h7E81;
    for (int f = 0; f < 3; f++) begin
      push_frame(w[f]);
      sb.push_back(ev(1'b1, 1'b1, 4'b0111, w[f][15:12]));
    end
    n = sb.size();
    last_ack = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      e = sb.pop_front(); o = {wr_ack, busy, an, digit}; n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", i, o, e);
      end
      if (wr_ack === 1'b1) begin
        n_cmp++;
        if (i - last_ack !== 17) begin
          n_err++;
          $display("FAIL ack_spacing cyc%0d: got %0d want 17", i, i - last_ack);
        end
        last_ack = i;
      end
      if (i == 0)  wr_data = w[1];
      if (i == 17) wr_data = w[2];
      if (i == n - 1) wr_req = 1'b0;
    end
    n_cmp++;
    if (last_ack !== 50) begin
      n_err++;
      $display("FAIL ack_count: got last ack at %0d want 50", last_ack);
    end
  endtask

  initial begin
    rst = 1'b0; wr_req = 1'b0; wr_data = '0; blank = 1'b0;
    test_reset;
    test_first_load;
    test_mid_frame;
    test_blank;
    test_reset_mid_load;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
